imu_seq: RTL
============

Name: imu_seq

Overview:
- Sequencer that owns the 16-bit SPI monarch and drives its snd/cmd/done/resp handshake.
- After reset it waits for sensor power-up, then issues a fixed list of inertial-sensor configuration writes.
- It then services data-ready interrupts by reading yaw-rate low/high bytes and presenting a 16-bit sample with a valid pulse.
- Sits between the SPI monarch and the heading/integration logic.

Parameters:
- PWR_WAIT_W, 16, width of the power-up wait counter; the wait is 2^PWR_WAIT_W clk cycles.
- N_INIT, 3, number of configuration writes in the init list.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- INT  input  1  sensor data-ready (asynchronous, active-high)
- spi_done  input  1  one-cycle pulse from the SPI monarch when a transaction completes
- spi_resp  input  16  SPI response; valid in the cycle spi_done is high
- spi_snd  output  1  one-cycle transaction start to the SPI monarch
- spi_cmd  output  16  command word; held stable from spi_snd until spi_done
- init_done  output  1  level; high once all init writes have completed
- yaw_rt  output  16  latest yaw rate {high byte, low byte}
- vld  output  1  one-cycle pulse when yaw_rt updates

Behaviour:
- Clock and reset: clk, with rst_n asynchronous active-low.
- Reset values: spi_snd=0, spi_cmd=16'h0000, init_done=0, yaw_rt=16'h0000, vld=0, state=PWR_WAIT, counters=0, int_pend=0.
- INT handling:
  - INT passes through a 2-flop synchronizer; a rising edge of the synchronized signal sets int_pend.
  - int_pend is set in any state after init_done.
  - int_pend is cleared in the cycle a read sequence starts (spi_snd for the first read).
  - If a set and a clear occur in the same cycle, set wins.
- Init command list (index 0..N_INIT-1): 16'h0D02 (INT enable on data ready), 16'h1160 (gyro ODR 416 Hz), 16'h1440 (rounding on).
- Read command list: 16'hA600 (yaw low), 16'hA700 (yaw high). Bit 15 set means read; the low byte is don't-care.
- States:
  - PWR_WAIT: counts up each cycle. When the counter reaches all ones, go to INIT_SND with idx=0.
  - INIT_SND: drive spi_cmd=init[idx] and pulse spi_snd for 1 cycle, then go to INIT_WT.
  - INIT_WT: on spi_done, if idx==N_INIT-1 set init_done and go to IDLE; otherwise increment idx, go to INIT_SND. spi_resp is ignored.
  - IDLE: if int_pend, go to RD_SND with ridx=0.
  - RD_SND: drive spi_cmd=rd[ridx] and pulse spi_snd, then go to RD_WT.
  - RD_WT: on spi_done, capture spi_resp[7:0] into the low or high byte staging register per ridx.
    - ridx==0: go to RD_SND with ridx=1.
    - ridx==1: load yaw_rt={spi_resp[7:0], low_byte}, pulse vld on the next cycle, go to IDLE.
- Spacing: spi_snd is never asserted in the same cycle as spi_done. There is at least one idle cycle between transactions.
- spi_cmd timing: registered, updated in the cycle spi_snd asserts, held until the next *_SND state.
- Latency: vld is asserted exactly 1 cycle after the second spi_done of a read pair.
- An INT edge arriving during a read pair is remembered via int_pend and serviced after returning to IDLE. Multiple edges collapse to one pending read.
- spi_done in any state other than *_WT is ignored.
- Reset mid-transaction: everything returns to PWR_WAIT. The SPI monarch is reset by the same rst_n.
- init_done, once set, stays high until reset.

Optional Feature:
- Macro: IMU_SEQ_PITCH_EN.
- When defined:
  - Adds output pitch_rt[15:0] (reset 16'h0000).
  - Each read sequence first reads 16'hA200 and 16'hA300 (pitch low/high), then yaw low/high, giving ridx 0..3.
  - pitch_rt and yaw_rt update together in the cycle before the single vld pulse.
- When undefined: no pitch_rt port and a two-read sequence only.

Decomposition:
- Package imu_seq_pkg:
  - state enum typedef.
  - INIT_CMDS array constant.
  - RD_YAW_L/RD_YAW_H (and RD_PITCH_L/H) command constants.
  - Default PWR_WAIT_W.
- Sub-module int_sync: 2-flop synchronizer plus rising-edge detect, output rise pulse.

Test Plan:
- Reset, PWR_WAIT_W overridden to 4 in the bench, SPI model returning done 20 cycles after snd -> first spi_snd at cycle 16 with cmd 16'h0D02, then 16'h1160 and 16'h1440; init_done rises the cycle after the 3rd done.
- After init, pulse INT; model returns 16'h00CD for the A6 read and 16'h00AB for the A7 read -> spi_cmd sequence A600, A700; yaw_rt=16'hABCD with one vld pulse 1 cycle after the 2nd done.
- INT pulses twice during a read pair -> exactly one additional read pair follows; no third pair.
- INT asserted before init_done -> ignored; no read commands until the first INT edge after init.
- Assert rst_n low while in RD_WT -> all outputs at reset values; restarts at PWR_WAIT; stale spi_done after reset release is ignored.
- With IMU_SEQ_PITCH_EN defined, responses 0x11,0x22,0x33,0x44 -> cmds A200,A300,A600,A700; pitch_rt=16'h2211, yaw_rt=16'h4433, single vld.

Source files
------------

// File: rtl/imu_seq_pkg.sv
// Shared types and command constants for the IMU sequencer.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SND,
    INIT_WT,
    IDLE,
    RD_SND,
    RD_WT
  } state_t;

  localparam int PWR_WAIT_W_DEF = 16;
  localparam int N_INIT_MAX     = 3;

  // Index 0 is issued first: INT on data-ready, gyro ODR 416 Hz, rounding on.
  localparam logic [N_INIT_MAX-1:0][15:0] INIT_CMDS = {16'h1440, 16'h1160, 16'h0D02};

  localparam logic [15:0] RD_YAW_L   = 16'hA600;
  localparam logic [15:0] RD_YAW_H   = 16'hA700;
  localparam logic [15:0] RD_PITCH_L = 16'hA200;
  localparam logic [15:0] RD_PITCH_H = 16'hA300;

endpackage

// File: rtl/imu_seq_if.sv
// Command/response handshake between the sequencer (master) and the SPI monarch (slave).
interface imu_seq_if;
  logic        spi_snd;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_resp;

  modport master (output spi_snd, spi_cmd, input spi_done, spi_resp);
  modport slave  (input spi_snd, spi_cmd, output spi_done, spi_resp);
endinterface

// File: rtl/imu_seq_int_sync.sv
// Two-flop synchronizer for the sensor INT line plus rising-edge detect.
// Rise pulse lasts one cycle, two to three clocks after the async edge; no backpressure.
module imu_seq_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], async_in};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/imu_seq.sv
// IMU sequencer: power-up wait, init writes, then INT-driven yaw (and pitch with
// IMU_SEQ_PITCH_EN) reads; sample + vld one cycle after the last spi_done.
module imu_seq
  import imu_seq_pkg::*;
#(
  parameter int PWR_WAIT_W = PWR_WAIT_W_DEF,
  parameter int N_INIT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  imu_seq_if.master   spi,
  output logic        init_done,
  output logic [15:0] yaw_rt,
`ifdef IMU_SEQ_PITCH_EN
  output logic [15:0] pitch_rt,
`endif
  output logic        vld
);

`ifdef IMU_SEQ_PITCH_EN
  localparam int N_RD = 4;
`else
  localparam int N_RD = 2;
`endif
  localparam int RIDX_W = $clog2(N_RD);
  localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_INIT - 1);
  localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(N_RD - 1);

  function automatic logic [15:0] rd_cmd(input logic [RIDX_W-1:0] r);
`ifdef IMU_SEQ_PITCH_EN
    case (r)
      2'd0:    rd_cmd = RD_PITCH_L;
      2'd1:    rd_cmd = RD_PITCH_H;
      2'd2:    rd_cmd = RD_YAW_L;
      default: rd_cmd = RD_YAW_H;
    endcase
`else
    rd_cmd = (r == 1'b1) ? RD_YAW_H : RD_YAW_L;
`endif
  endfunction

  state_t                state;
  logic [PWR_WAIT_W-1:0] cnt;
  logic [PWR_WAIT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [RIDX_W-1:0]     ridx;
  logic [RIDX_W-1:0]     ridx_nxt;
  logic                  int_pend;
  logic                  int_rise;
  logic [7:0]            yaw_lo;
`ifdef IMU_SEQ_PITCH_EN
  logic [7:0]            pitch_lo;
  logic [7:0]            pitch_hi;
`endif
  logic                  unused_resp_hi;

  assign cnt_nxt  = cnt + PWR_WAIT_W'(1);
  assign idx_nxt  = idx + IDX_W'(1);
  assign ridx_nxt = ridx + RIDX_W'(1);
  // Only the register data byte of each response carries information.
  assign unused_resp_hi = ^spi.spi_resp[15:8];

  imu_seq_int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .rise     (int_rise)
  );

  // snd/cmd are loaded on the edge entering *_SND so the pulse lines up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      idx         <= '0;
      ridx        <= '0;
      int_pend    <= 1'b0;
      spi.spi_snd <= 1'b0;
      spi.spi_cmd <= '0;
      init_done   <= 1'b0;
      yaw_rt      <= '0;
      yaw_lo      <= '0;
      vld         <= 1'b0;
`ifdef IMU_SEQ_PITCH_EN
      pitch_rt    <= '0;
      pitch_lo    <= '0;
      pitch_hi    <= '0;
`endif
    end else begin
      spi.spi_snd <= 1'b0;
      vld         <= 1'b0;
      case (state)
        PWR_WAIT: begin
          cnt <= cnt_nxt;
          if (cnt == '1) begin
            state       <= INIT_SND;
            idx         <= '0;
            spi.spi_snd <= 1'b1;
            spi.spi_cmd <= INIT_CMDS[0];
          end
        end
        INIT_SND: state <= INIT_WT;
        INIT_WT: begin
          if (spi.spi_done) begin
            if (idx == IDX_LAST) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              idx         <= idx_nxt;
              state       <= INIT_SND;
              spi.spi_snd <= 1'b1;
              spi.spi_cmd <= INIT_CMDS[idx_nxt];
            end
          end
        end
        IDLE: begin
          if (int_pend) begin
            int_pend    <= 1'b0;
            ridx        <= '0;
            state       <= RD_SND;
            spi.spi_snd <= 1'b1;
            spi.spi_cmd <= rd_cmd('0);
          end
        end
        RD_SND: state <= RD_WT;
        RD_WT: begin
          if (spi.spi_done) begin
            if (ridx == RIDX_LAST) begin
`ifdef IMU_SEQ_PITCH_EN
              pitch_rt <= {pitch_hi, pitch_lo};
`endif
              yaw_rt <= {spi.spi_resp[7:0], yaw_lo};
              vld    <= 1'b1;
              state  <= IDLE;
            end else begin
`ifdef IMU_SEQ_PITCH_EN
              case (ridx)
                2'd0:    pitch_lo <= spi.spi_resp[7:0];
                2'd1:    pitch_hi <= spi.spi_resp[7:0];
                default: yaw_lo   <= spi.spi_resp[7:0];
              endcase
`else
              yaw_lo <= spi.spi_resp[7:0];
`endif
              ridx        <= ridx_nxt;
              state       <= RD_SND;
              spi.spi_snd <= 1'b1;
              spi.spi_cmd <= rd_cmd(ridx_nxt);
            end
          end
        end
        default: state <= PWR_WAIT;
      endcase
      // Placed after the IDLE clear so a coincident new edge keeps the request.
      if (int_rise && init_done) int_pend <= 1'b1;
    end
  end

endmodule
